// File: rtl/neighborhood_window_module_pkg.sv
// Shared definitions for the 3x3 RGB444 neighbourhood window builder:
// pixel width, packed-window field offsets and FSM state encoding.
package neighborhood_window_module_pkg;

  localparam int PIX_W = 12;
  localparam int WIN_W = 9 * PIX_W;

  localparam int CENTER_LSB    = 96;
  localparam int LEFT_LSB      = 84;
  localparam int RIGHT_LSB     = 72;
  localparam int UP_LSB        = 60;
  localparam int DOWN_LSB      = 48;
  localparam int UPLEFT_LSB    = 36;
  localparam int UPRIGHT_LSB   = 24;
  localparam int DOWNLEFT_LSB  = 12;
  localparam int DOWNRIGHT_LSB = 0;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/neighborhood_window_module_line_buffer.sv
// One image line of pixel storage; the read returns the previous content of
// the addressed location even when it is written in the same cycle.
module line_buffer_module
  import neighborhood_window_module_pkg::*;
#(
  parameter int DEPTH  = 640,
  parameter int DATA_W = PIX_W
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/neighborhood_window_module.sv
// Raster-stream to 3x3 neighbourhood window: two chained line buffers feed a
// 3x3 shift array; edges are zero-masked from the centre coordinates.
module neighborhood_window_module
  import neighborhood_window_module_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PIX_W-1:0]              pixel_in,
  input  logic                          pixel_valid,
  input  logic                          frame_start,
  output logic                          in_ready,
  output logic [WIN_W-1:0]              color_data,
  output logic                          window_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  center_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] center_y,
  output logic                          frame_done
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  function automatic pix_t keep(input pix_t p, input logic en);
    return en ? p : '0;
  endfunction

  state_t        state_q, state_d;
  logic [XW-1:0] in_x_q, cx_q, wr_addr;
  logic [YW-1:0] in_y_q, cy_q;
  logic          acc, start, take, shift_en, emit, last_ctr;
  pix_t          lb1_rd, lb2_rd, bot_pix;

  assign in_ready = (state_q != ST_FLUSH);
  assign acc      = pixel_valid & in_ready;
  assign start    = acc & frame_start;
  assign take     = acc & (frame_start | (state_q != ST_IDLE));
  assign shift_en = take | (state_q == ST_FLUSH);
  assign emit     = ((state_q == ST_RUN) & acc & ~frame_start) | (state_q == ST_FLUSH);
  assign last_ctr = (cx_q == X_LAST) && (cy_q == Y_LAST);
  assign wr_addr  = start ? '0 : in_x_q;
  // Flush cycles push blank pixels so the line-buffer chain keeps its alignment.
  assign bot_pix  = (state_q == ST_FLUSH) ? '0 : pixel_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FILL;
      ST_FILL:  if (start) state_d = ST_FILL;
                else if (acc && in_x_q == '0 && in_y_q == YW'(1)) state_d = ST_RUN;
      ST_RUN:   if (start) state_d = ST_FILL;
                else if (acc && in_x_q == X_LAST && in_y_q == Y_LAST) state_d = ST_FLUSH;
      ST_FLUSH: if (last_ctr) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_x_q <= '0;
      in_y_q <= '0;
      cx_q   <= '0;
      cy_q   <= '0;
    end else if (start) begin
      in_x_q <= XW'(1);
      in_y_q <= '0;
      cx_q   <= '0;
      cy_q   <= '0;
    end else begin
      if (shift_en) begin
        in_x_q <= (in_x_q == X_LAST) ? '0 : in_x_q + 1'b1;
        if (in_x_q == X_LAST) in_y_q <= (in_y_q == Y_LAST) ? '0 : in_y_q + 1'b1;
      end
      if (emit) begin
        cx_q <= (cx_q == X_LAST) ? '0 : cx_q + 1'b1;
        if (cx_q == X_LAST) cy_q <= (cy_q == Y_LAST) ? '0 : cy_q + 1'b1;
      end
    end
  end

  line_buffer_module #(.DEPTH(IMG_WIDTH), .DATA_W(PIX_W)) u_lb_row1 (
    .clk(clk), .wr_en(shift_en), .wr_addr(wr_addr), .wr_data(bot_pix),
    .rd_addr(wr_addr), .rd_data(lb1_rd)
  );

  line_buffer_module #(.DEPTH(IMG_WIDTH), .DATA_W(PIX_W)) u_lb_row2 (
    .clk(clk), .wr_en(shift_en), .wr_addr(wr_addr), .wr_data(lb1_rd),
    .rd_addr(wr_addr), .rd_data(lb2_rd)
  );

  // Stage p0: 3x3 shift array, rows [0]=y-1 .. [2]=y+1, column [2] newest.
  pix_t win_p0  [3][3];
  pix_t win_nxt [3][3];

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nxt[r][0] = win_p0[r][1];
      win_nxt[r][1] = win_p0[r][2];
    end
    win_nxt[0][2] = lb2_rd;
    win_nxt[1][2] = lb1_rd;
    win_nxt[2][2] = bot_pix;
  end

  always_ff @(posedge clk) begin
    if (shift_en) win_p0 <= win_nxt;
  end

  logic             has_l, has_r, has_u, has_d;
  logic [WIN_W-1:0] color_d;

  assign has_l = (cx_q != '0);
  assign has_r = (cx_q != X_LAST);
  assign has_u = (cy_q != '0);
  assign has_d = (cy_q != Y_LAST);

  always_comb begin
    color_d = '0;
    color_d[CENTER_LSB    +: PIX_W] = win_nxt[1][1];
    color_d[LEFT_LSB      +: PIX_W] = keep(win_nxt[1][0], has_l);
    color_d[RIGHT_LSB     +: PIX_W] = keep(win_nxt[1][2], has_r);
    color_d[UP_LSB        +: PIX_W] = keep(win_nxt[0][1], has_u);
    color_d[DOWN_LSB      +: PIX_W] = keep(win_nxt[2][1], has_d);
    color_d[UPLEFT_LSB    +: PIX_W] = keep(win_nxt[0][0], has_u & has_l);
    color_d[UPRIGHT_LSB   +: PIX_W] = keep(win_nxt[0][2], has_u & has_r);
    color_d[DOWNLEFT_LSB  +: PIX_W] = keep(win_nxt[2][0], has_d & has_l);
    color_d[DOWNRIGHT_LSB +: PIX_W] = keep(win_nxt[2][2], has_d & has_r);
  end

  // Stage p1: registered window outputs.
  logic [WIN_W-1:0] color_p1;
  logic             vld_p1, done_p1;
  logic [XW-1:0]    cx_p1;
  logic [YW-1:0]    cy_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      color_p1 <= '0;
      vld_p1   <= 1'b0;
      done_p1  <= 1'b0;
      cx_p1    <= '0;
      cy_p1    <= '0;
    end else begin
      vld_p1  <= emit;
      done_p1 <= emit & last_ctr;
      if (emit) begin
        color_p1 <= color_d;
        cx_p1    <= cx_q;
        cy_p1    <= cy_q;
      end
    end
  end

  assign color_data   = color_p1;
  assign window_valid = vld_p1;
  assign frame_done   = done_p1;
  assign center_x     = cx_p1;
  assign center_y     = cy_p1;

endmodule

// File: tb/tb_neighborhood_window_module.sv
// Directed bench for the 3x3 window builder on a 4x3 image, checked every
// cycle against a pixel-array model of the expected window sequence.
module tb_neighborhood_window_module;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
  localparam logic [107:0] CORNER   = 108'h001000002000005000000000006;
  localparam logic [107:0] INTERIOR = 108'h00600500700200A00100300900B;
  localparam logic [107:0] LASTWIN  = 108'h00C00B000008000007000000000;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [11:0]  pixel_in = '0;
  logic         pixel_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic         in_ready;
  logic [107:0] color_data;
  logic         window_valid;
  logic [1:0]   center_x;
  logic [1:0]   center_y;
  logic         frame_done;

  int vectors = 0;
  int miscompares = 0;
  bit plan_frame = 1'b0;

  neighborhood_window_module #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .in_ready(in_ready), .color_data(color_data),
    .window_valid(window_valid), .center_x(center_x), .center_y(center_y),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [107:0] act, input logic [107:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the frame as a pixel array; a window is the 3x3 neighbourhood of a
  // centre index, with zeros outside the image.
  logic [11:0] fpix [N];
  int  cnt = 0;
  bit  active = 1'b0;
  int  flush_left = 0;
  bit  exp_vld = 1'b0;
  bit  exp_done = 1'b0;
  int  exp_cx = 0;
  int  exp_cy = 0;
  logic [107:0] exp_data = '0;

  function automatic logic [11:0] px(input int x, input int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return 12'h000;
    return fpix[y*W + x];
  endfunction

  function automatic logic [107:0] window_of(input int c);
    int x = c % W;
    int y = c / W;
    return {px(x, y), px(x-1, y), px(x+1, y), px(x, y-1), px(x, y+1),
            px(x-1, y-1), px(x+1, y-1), px(x-1, y+1), px(x+1, y+1)};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      active = 1'b0; flush_left = 0; cnt = 0; exp_vld = 1'b0; exp_done = 1'b0;
    end else begin
      exp_vld = 1'b0;
      exp_done = 1'b0;
      if (flush_left > 0) begin
        exp_vld = 1'b1;
        exp_data = window_of(N - flush_left);
        exp_cx = (N - flush_left) % W;
        exp_cy = (N - flush_left) / W;
        flush_left--;
        exp_done = (flush_left == 0);
      end else if (pixel_valid) begin
        if (frame_start) begin active = 1'b1; cnt = 0; end
        if (active) begin
          fpix[cnt] = pixel_in;
          cnt++;
          if (cnt >= W + 2) begin
            exp_vld = 1'b1;
            exp_data = window_of(cnt - W - 2);
            exp_cx = (cnt - W - 2) % W;
            exp_cy = (cnt - W - 2) / W;
          end
          if (cnt == N) begin active = 1'b0; flush_left = W + 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("in_ready", 108'(in_ready), 108'(flush_left == 0));
      chk("window_valid", 108'(window_valid), 108'(exp_vld));
      chk("frame_done", 108'(frame_done), 108'(exp_done));
      if (exp_vld && window_valid) begin
        chk("color_data", color_data, exp_data);
        chk("center_x", 108'(center_x), 108'(exp_cx));
        chk("center_y", 108'(center_y), 108'(exp_cy));
        if (plan_frame && exp_cx == 0 && exp_cy == 0) begin
          chk("corner_model", exp_data, CORNER);
          chk("corner_dut", color_data, CORNER);
        end
        if (plan_frame && exp_cx == 1 && exp_cy == 1) begin
          chk("interior_model", exp_data, INTERIOR);
          chk("interior_dut", color_data, INTERIOR);
        end
        if (plan_frame && exp_cx == W-1 && exp_cy == H-1) begin
          chk("last_model", exp_data, LASTWIN);
          chk("last_dut", color_data, LASTWIN);
          chk("last_done", 108'(frame_done), 108'(1));
        end
      end
    end
  end

  // Drives one pixel at a negedge; returns at the negedge after it is accepted.
  task automatic send(input logic [11:0] p, input logic fs);
    int guard = 0;
    pixel_in = p; pixel_valid = 1'b1; frame_start = fs;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: in_ready stuck at %0b, want 1", in_ready);
    end
    @(negedge clk);
    pixel_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_window_valid"}, 108'(window_valid), 108'(0));
    chk({tag, "_color_data"}, color_data, 108'(0));
    chk({tag, "_center_x"}, 108'(center_x), 108'(0));
    chk({tag, "_center_y"}, 108'(center_y), 108'(0));
    chk({tag, "_frame_done"}, 108'(frame_done), 108'(0));
    chk({tag, "_in_ready"}, 108'(in_ready), 108'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    idle(3);
    check_zero_outputs("reset");
    reset = 1'b1;
    idle(2);

    // Frame A: back-to-back, test-plan values; B follows straight after the flush.
    plan_frame = 1'b1;
    for (int k = 0; k < N; k++) send(12'(k + 1), k == 0);
    // Frame B: same values with random pixel_valid gaps.
    for (int k = 0; k < N; k++) begin
      send(12'(k + 1), k == 0);
      idle($urandom_range(0, 2));
    end
    idle(W + 3);
    plan_frame = 1'b0;

    // Frame C: abort at index 6, then a full new frame of random pixels.
    for (int k = 0; k < 6; k++) send(12'h100 + 12'(k), k == 0);
    for (int k = 0; k < N; k++) send(12'($urandom_range(0, 4095)), k == 0);
    idle(W + 3);

    // Mid-RUN asynchronous reset, then dropped pixels, then a clean frame.
    for (int k = 0; k < 8; k++) send(12'h200 + 12'(k), k == 0);
    #2 reset = 1'b0;
    #1 check_zero_outputs("midreset");
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) send(12'h300 + 12'(k), 1'b0);
    idle(2);
    for (int k = 0; k < N; k++) send(12'($urandom_range(0, 4095)), k == 0);
    idle(W + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/neighborhood_window_module.md
# neighborhood_window_module

Builds the 3x3 RGB444 neighbourhood window consumed by the per-pixel filter modules (green/red/blue/kernel filters) from a raster-order pixel stream. Sits between the frame source and the filter stage and produces the 108-bit packed window those filters decode. Two line buffers and a 3x3 register array emit one window per image pixel, with zero padding outside the image and a flush phase at frame end.

## Interface
- IMG_WIDTH, 640, pixels per line (W), >= 2
- IMG_HEIGHT, 480, lines per frame (H), >= 2
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- pixel_in  in  12  RGB444 pixel {R[11:8],G[7:4],B[3:0]}
- pixel_valid  in  1  pixel_in valid this cycle
- frame_start  in  1  qualifies first pixel of a frame (sampled only with pixel_valid)
- in_ready  out  1  block accepts a pixel this cycle
- color_data  out  108  packed window (layout below)
- window_valid  out  1  color_data valid, one-cycle pulse per window
- center_x  out  $clog2(W)  column of window centre
- center_y  out  $clog2(H)  row of window centre
- frame_done  out  1  pulse with the last window of a frame

## Operation
- Packing: [107:96] centre, [95:84] left, [83:72] right, [71:60] up, [59:48] down, [47:36] up-left, [35:24] up-right, [23:12] down-left, [11:0] down-right.
- Accept = pixel_valid & in_ready. Pixels arrive in raster order; linear index k = y*W + x.
- Window for centre k is emitted after input k+W+1 is accepted (RUN), or during FLUSH for k >= N-W-1 (N = W*H).
- Neighbours outside the image (x-1<0, x+1>=W, y-1<0, y+1>=H) are 12'h000. Masking uses centre coordinates, never line-buffer contents.
- FSM:
  - IDLE: in_ready=1. Accept with frame_start -> FILL, input counters at (0,0). Accept without frame_start: pixel dropped.
  - FILL: in_ready=1. No windows until W+1 pixels are accepted. Then -> RUN.
  - RUN: one window per accept. Accepting index N-1 -> FLUSH.
  - FLUSH: in_ready=0. Exactly W+1 consecutive cycles, one window each (centres N-W-1..N-1). frame_done with the final window. -> IDLE.
- Accept with frame_start in FILL/RUN aborts the current frame: no further windows for it, no flush. The pixel becomes (0,0) of a new frame, state FILL.
- pixel_valid gaps stall the pipeline. No window is emitted on non-accept cycles in FILL/RUN.
- No output backpressure. The consumer takes every window_valid.

## Timing
- Reset (reset=0, asynchronous): state IDLE, counters 0, color_data=0, window_valid=0, center_x=0, center_y=0, frame_done=0, in_ready=1 (combinational from state).
- Outputs are registered. window_valid rises the cycle after the triggering accept (RUN) or after each FLUSH cycle. Throughput 1 window/cycle.
- Minimum frame period: N accepts + W+1 flush cycles. The first pixel of the next frame is accepted the cycle after the last flush cycle.
- Line buffers are read-before-write at the same address in the same cycle.
- Reset deassertion mid-frame resumes in IDLE. A partial frame is never completed.

## Structure
- Shared package/include: window field offsets (CENTER_LSB … DOWNRIGHT_LSB), PIX_W=12, state encoding (IDLE, FILL, RUN, FLUSH).
- Sub-module line_buffer_module: depth IMG_WIDTH x 12 bits, one write and one read port, read-before-write. Two instances are chained for rows y-1 and y-2.
- Top holds the FSM, input/centre counters, 3x3 shift array, edge masking and output registers.

## Test plan
Use W=4, H=3, pixel value = k+1 (12'h001…12'h00C).
- Corner: after index 5 is accepted, the next cycle has window_valid=1, centre (0,0), color_data fields centre 001, right 002, down 005, down-right 006, others 000.
- Interior: centre (1,1) is emitted after index 10: centre 006, left 005, right 007, up 002, down 00A, up-left 001, up-right 003, down-left 009, down-right 00B.
- Flush: after index 11, in_ready=0 for 5 cycles, windows for centres 7..11. Last window is centre 00C, left 00B, up 008, up-left 007, others 000, with frame_done=1. Exactly 12 windows per frame.
- Stall: random pixel_valid gaps give the same 12 windows in the same order, with no window_valid on idle cycles.
- Abort: frame_start asserted at index 6 -> no windows for the old frame beyond those already emitted. The new frame's first window is centre (0,0) after 5 more accepts.
- Reset: reset=0 asserted mid-RUN -> all outputs 0 immediately. After release, pixels without frame_start are dropped with no window_valid.
